lcd_logic: RTL and testbench
============================

Name: lcd_logic

Overview:
- Drives an HD44780-compatible character LCD over its 8-bit parallel bus from a single system clock.
- After reset it runs a fixed power-on initialisation command sequence.
- It then writes MCU-supplied words to the display as a command or as character data, selected by bit 8.
- Sits between the MCU interface register (from_MCU) and the LCD connector pins.

Parameters:
- STEP_CYCLES, 2624, Clock cycles per bus step. Default equals 2.624 ms at a 1 MHz Clock.
- E_RISE, 2, Cycle within a step at which e goes high. This is the address/data setup time.
- E_FALL, 80, Cycle within a step at which e goes low. Must satisfy E_RISE < E_FALL < STEP_CYCLES.

Ports:
- Clock  input  1  system clock; all logic on rising edge
- Reset  input  1  synchronous, active-high reset
- from_MCU  input  9  bit 8 = 1 data write (rs=1), 0 command write (rs=0); bits 7:0 = byte
- data  output  8  LCD DB7..DB0
- rs  output  1  register select (0 command, 1 data)
- rw  output  1  read/write; always 0 (write only)
- e  output  1  LCD enable strobe

Behaviour:
- One clock domain, synchronous active-high reset.
- While Reset is high: data=0, rs=0, rw=0, e=0, step counter=0, sequencer at INIT0, last-written register cleared, first_run flag set.
- Step timer: counts 0..STEP_CYCLES-1 and wraps. The cycle on which it wraps is the step boundary. The first step begins on the first cycle after Reset deasserts.
- Within a step that performs a write:
  - data and rs are loaded at count 0 and held stable for the whole step.
  - e=1 for counts E_RISE through E_FALL-1, and e=0 otherwise.
  - The falling edge of e therefore occurs with data stable.
- Sequencer states, advancing one state per step boundary:
  - INIT0: data=0x3C, rs=0 (function set: 8-bit, 2 lines, 5x10)
  - INIT1: data=0x06, rs=0 (entry mode: increment, no shift)
  - INIT2: data=0x01, rs=0 (clear display)
  - INIT3: data=0x0F, rs=0 (display on, cursor on, blink)
  - INIT4: data=0x80, rs=0 (DDRAM address 0)
  - SETTLE: no write. e stays 0; data and rs hold their previous values.
  - RUN: absorbing state; it stays here until Reset.
- RUN behaviour at each step start:
  - from_MCU is sampled.
  - If first_run is set, or the sample differs from the last written value, the step is a write step. data=sample[7:0], rs=sample[8], the e pulse is issued, the last-written register is updated and first_run is cleared.
  - Otherwise it is an idle step: e=0, and data and rs hold.
- from_MCU changes in mid-step are ignored until the next step start. Data is never changed while e=1.
- rw is constant 0 in every state.
- Reset asserted mid-step or mid-sequence aborts immediately on the next edge, forcing e=0. The full init sequence restarts after release.
- Timing from Reset release, in step units:
  - 0x3C is on the bus from step 0.
  - The first RUN write occurs in step 6.

Decomposition:
- Package lcd_pkg:
  - State enum: INIT0..INIT4, SETTLE, RUN.
  - Command constants: CMD_FUNC_SET=0x3C, CMD_ENTRY=0x06, CMD_CLEAR=0x01, CMD_DISP_ON=0x0F, CMD_HOME_ADDR=0x80.
- Sub-module lcd_step_timer:
  - Parameterised by STEP_CYCLES, E_RISE and E_FALL.
  - Outputs step_start (1-cycle pulse at count 0) and e_window (high for E_RISE..E_FALL-1).
  - The top level ANDs e_window with a per-step write flag.

Test Plan:
- Reset held for ≥1 step with from_MCU=0x105 -> data=0x00, rs=0, rw=0, e=0 throughout.
- Release Reset; check 36 cycles into step 0 -> data=0x3C, rs=0, rw=0, e=1; at E_FALL e=0 with data still 0x3C.
- Check at the same offset in steps 1, 2, 3, 4 -> data 0x06, 0x01, 0x0F, 0x80 respectively; rs=0, e=1 each time.
- Step 5 -> e never asserted.
- Step 6, with from_MCU=0x105 -> data=0x05, rs=1, rw=0, e=1.
- Step 7 with from_MCU unchanged -> e=0 all step.
- Change from_MCU to 0x041 mid-step 8 -> no bus change until step 9. In step 9: data=0x41, rs=0, e=1.
- Assert Reset while e=1 in step 2 -> next edge: all outputs 0. After release the sequence restarts at 0x3C.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and command constants for the HD44780 character LCD driver.
package lcd_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned MCU_W  = BYTE_W + 1;

    typedef enum logic [2:0] {
        INIT0,
        INIT1,
        INIT2,
        INIT3,
        INIT4,
        SETTLE,
        RUN
    } lcd_state_e;

    // MCU word: bit 8 selects data (1) or command (0) register
    typedef struct packed {
        logic              rs;
        logic [BYTE_W-1:0] val;
    } lcd_word_t;

    localparam logic [BYTE_W-1:0] CMD_FUNC_SET  = 8'h3C;
    localparam logic [BYTE_W-1:0] CMD_ENTRY     = 8'h06;
    localparam logic [BYTE_W-1:0] CMD_CLEAR     = 8'h01;
    localparam logic [BYTE_W-1:0] CMD_DISP_ON   = 8'h0F;
    localparam logic [BYTE_W-1:0] CMD_HOME_ADDR = 8'h80;

    function automatic logic [BYTE_W-1:0] init_cmd(input lcd_state_e st);
        logic [BYTE_W-1:0] cmd;
        unique case (st)
            INIT1:   cmd = CMD_ENTRY;
            INIT2:   cmd = CMD_CLEAR;
            INIT3:   cmd = CMD_DISP_ON;
            INIT4:   cmd = CMD_HOME_ADDR;
            default: cmd = CMD_FUNC_SET;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/lcd_step_timer.sv
// Free-running bus step timer: marks step starts and the cycles where e may be high.
module lcd_step_timer #(
    parameter int unsigned STEP_CYCLES = 2624,
    parameter int unsigned E_RISE      = 2,
    parameter int unsigned E_FALL      = 80
) (
    input  logic clk,
    input  logic rst,
    output logic step_start,
    output logic e_window
);

    localparam int unsigned CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(STEP_CYCLES - 1)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // e_window looks one cycle ahead so the registered e lines up with the count
    assign step_start = (cnt_q == '0);
    assign e_window   = (cnt_d >= CNT_W'(E_RISE)) && (cnt_d < CNT_W'(E_FALL));

endmodule

// File: rtl/lcd_logic.sv
// HD44780 8-bit bus driver: power-on init sequence, then MCU-driven command/data writes.
module lcd_logic
    import lcd_pkg::*;
#(
    parameter int unsigned STEP_CYCLES = 2624,
    parameter int unsigned E_RISE      = 2,
    parameter int unsigned E_FALL      = 80
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [MCU_W-1:0]  from_MCU,
    output logic [BYTE_W-1:0] data,
    output logic              rs,
    output logic              rw,
    output logic              e
);

    logic step_start;
    logic e_window;

    lcd_step_timer #(
        .STEP_CYCLES (STEP_CYCLES),
        .E_RISE      (E_RISE),
        .E_FALL      (E_FALL)
    ) u_timer (
        .clk        (Clock),
        .rst        (Reset),
        .step_start (step_start),
        .e_window   (e_window)
    );

    lcd_state_e        state_q, state_d;
    logic [BYTE_W-1:0] data_q, data_d;
    logic              rs_q, rs_d;
    logic              wr_q, wr_d;
    logic              e_q, e_d;
    lcd_word_t         last_q, last_d;
    logic              first_q, first_d;
    lcd_word_t         mcu_w;

    assign mcu_w = lcd_word_t'(from_MCU);

    // Decisions are taken only at step start; everything holds for the rest of the step
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        rs_d    = rs_q;
        wr_d    = wr_q;
        last_d  = last_q;
        first_d = first_q;

        if (step_start) begin
            wr_d = 1'b0;
            unique case (state_q)
                INIT0:   state_d = INIT1;
                INIT1:   state_d = INIT2;
                INIT2:   state_d = INIT3;
                INIT3:   state_d = INIT4;
                INIT4:   state_d = SETTLE;
                default: state_d = RUN;
            endcase

            if (state_q == RUN) begin
                if (first_q || (mcu_w != last_q)) begin
                    wr_d    = 1'b1;
                    data_d  = mcu_w.val;
                    rs_d    = mcu_w.rs;
                    last_d  = mcu_w;
                    first_d = 1'b0;
                end
            end else if (state_q != SETTLE) begin
                wr_d   = 1'b1;
                data_d = init_cmd(state_q);
                rs_d   = 1'b0;
            end
        end

        e_d = e_window & wr_d;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= INIT0;
            data_q  <= '0;
            rs_q    <= 1'b0;
            wr_q    <= 1'b0;
            e_q     <= 1'b0;
            last_q  <= '0;
            first_q <= 1'b1;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rs_q    <= rs_d;
            wr_q    <= wr_d;
            e_q     <= e_d;
            last_q  <= last_d;
            first_q <= first_d;
        end
    end

    assign data = data_q;
    assign rs   = rs_q;
    assign rw   = 1'b0;
    assign e    = e_q;

endmodule

// File: tb/tb_lcd_logic.sv
// Scoreboard bench for lcd_logic against a step-level model of the LCD bus protocol.
module tb_lcd_logic;

    localparam int STEP = 300;
    localparam int ER   = 2;
    localparam int EF   = 80;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [8:0] mcu = 9'h105;
    logic [7:0] data;
    logic       rs;
    logic       rw;
    logic       e;

    lcd_logic #(
        .STEP_CYCLES (STEP),
        .E_RISE      (ER),
        .E_FALL      (EF)
    ) dut (
        .Clock    (clk),
        .Reset    (rst),
        .from_MCU (mcu),
        .data     (data),
        .rs       (rs),
        .rw       (rw),
        .e        (e)
    );

    always #5 clk = ~clk;

    int         checks   = 0;
    int         failures = 0;
    logic [8:0] sb_q[$];
    logic [7:0] init_cmds[5];

    // model state: what the bus should show and what the driver remembers
    logic [7:0] m_data;
    logic       m_rs;
    logic       m_wr;
    logic [8:0] m_last;
    bit         m_first;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_zero(input string nm);
        check({nm, "_data"}, 32'(data), 32'd0);
        check({nm, "_rs"},   32'(rs),   32'd0);
        check({nm, "_rw"},   32'(rw),   32'd0);
        check({nm, "_e"},    32'(e),    32'd0);
    endtask

    function automatic logic [8:0] pick_word();
        logic [8:0] w;
        case ($urandom_range(3))
            0:       w = 9'h105;
            1:       w = 9'h041;
            default: w = 9'($urandom);
        endcase
        return w;
    endfunction

    // Runs from Reset release (called at a negedge); abort_at >= 0 asserts Reset at that cycle
    task automatic run_seq(input int nsteps, input int abort_at, input bit directed);
        int s;
        int c;
        m_data  = 8'h00;
        m_rs    = 1'b0;
        m_wr    = 1'b0;
        m_last  = 9'h000;
        m_first = 1'b1;
        for (int kk = 0; kk < nsteps * STEP; kk++) begin
            s = kk / STEP;
            c = kk % STEP;
            check("rw", 32'(rw), 32'd0);
            check("data", 32'(data), 32'(m_data));
            check("rs", 32'(rs), 32'(m_rs));
            check("e", 32'(e), 32'(m_wr && (c >= ER) && (c < EF)));
            if (kk == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                check_zero("abort");
                sb_q.delete();
                return;
            end
            if (c == 0) begin
                if (s < 5) begin
                    m_wr = 1'b1; m_data = init_cmds[s]; m_rs = 1'b0;
                end else if (s == 5) begin
                    m_wr = 1'b0;
                end else if (m_first || (mcu != m_last)) begin
                    m_wr = 1'b1; m_data = mcu[7:0]; m_rs = mcu[8];
                    m_last = mcu; m_first = 1'b0;
                end else begin
                    m_wr = 1'b0;
                end
                if (m_wr) sb_q.push_back({m_rs, m_data});
            end else if (directed && s < 10) begin
                if (s == 8 && c == 150) mcu = 9'h041;
            end else begin
                if ($urandom_range(199) == 0) mcu = pick_word();
                if (c == STEP - 1 && $urandom_range(2) == 0) mcu = m_last;
            end
            @(negedge clk);
        end
    endtask

    // Monitor: every completed e pulse must match the next expected write
    initial begin
        logic [8:0] exp_w;
        bit         e_prev;
        int         hi;
        e_prev = 1'b0;
        hi     = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                e_prev = 1'b0;
                hi     = 0;
            end else begin
                if (e) hi++;
                if (e_prev && !e) begin
                    check("pulse_width", 32'(hi), 32'(EF - ER));
                    if (sb_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_pulse actual={rs,data}=0x%0h required=no pulse t=%0t",
                                 {rs, data}, $time);
                    end else begin
                        exp_w = sb_q.pop_front();
                        check("bus_at_fall", 32'({rs, data}), 32'(exp_w));
                    end
                    hi = 0;
                end
                e_prev = e;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        init_cmds[0] = 8'h3C;
        init_cmds[1] = 8'h06;
        init_cmds[2] = 8'h01;
        init_cmds[3] = 8'h0F;
        init_cmds[4] = 8'h80;

        rst = 1'b1;
        mcu = 9'h105;
        repeat (STEP + 5) begin
            @(negedge clk);
            check_zero("reset_hold");
        end

        rst = 1'b0;
        run_seq(20, -1, 1'b1);

        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_zero("reset2");
        end
        rst = 1'b0;
        run_seq(20, 2 * STEP + 40, 1'b0);

        repeat (10) begin
            @(negedge clk);
            check_zero("reset3");
        end
        rst = 1'b0;
        run_seq(14, -1, 1'b0);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
